// File: rtl/mem_share_pkg.sv
// rtl/mem_share_pkg.sv - shared parameter defaults and FSM encoding for the memory-share arbiter
//
// Purpose: single home for the arbiter's parameter defaults and its state type,
// so the top and any future users of the shared column-bank port agree on them.
package mem_share_pkg;

  localparam int RQSTR_NUM_DEF          = 4;
  localparam int BIN_CODE_LEN_DEF       = 2;
  localparam int RQST_ADDR_BITWIDTH_DEF = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_share_rr_prio_enc.sv
// rtl/mem_share_rr_prio_enc.sv - wrap-around masked priority encoder for round-robin selection
//
// Purpose: picks the first set request bit at index >= ptr_i; if none, the
// lowest set bit overall. Purely combinational.
// Ports:
//   rqst_i          request vector
//   ptr_i           priority pointer (search start index)
//   winner_onehot_o one-hot winner, zero when no request is set
//   winner_bin_o    binary winner index, zero when no request is set
module mem_share_rr_prio_enc
  import mem_share_pkg::*;
#(
  parameter int RQSTR_NUM    = RQSTR_NUM_DEF,
  parameter int BIN_CODE_LEN = BIN_CODE_LEN_DEF
) (
  input  logic [RQSTR_NUM-1:0]    rqst_i,
  input  logic [BIN_CODE_LEN-1:0] ptr_i,
  output logic [RQSTR_NUM-1:0]    winner_onehot_o,
  output logic [BIN_CODE_LEN-1:0] winner_bin_o
);

  logic                    w_hit_hi;
  logic                    w_hit_lo;
  logic [BIN_CODE_LEN-1:0] w_hi_bin;
  logic [BIN_CODE_LEN-1:0] w_lo_bin;

  always_comb begin
    w_hit_hi        = 1'b0;
    w_hit_lo        = 1'b0;
    w_hi_bin        = '0;
    w_lo_bin        = '0;
    winner_onehot_o = '0;
    winner_bin_o    = '0;
    // Scan downward so the last hit recorded is the lowest qualifying index.
    for (int i = RQSTR_NUM - 1; i >= 0; i--) begin
      if (rqst_i[i]) begin
        w_hit_lo = 1'b1;
        w_lo_bin = BIN_CODE_LEN'(i);
        if (i >= int'(ptr_i)) begin
          w_hit_hi = 1'b1;
          w_hi_bin = BIN_CODE_LEN'(i);
        end
      end
    end
    if (w_hit_hi) begin
      winner_bin_o = w_hi_bin;
    end else begin
      winner_bin_o = w_lo_bin;
    end
    if (w_hit_lo) begin
      winner_onehot_o = {{(RQSTR_NUM-1){1'b0}}, 1'b1} << winner_bin_o;
    end
  end

endmodule

// File: rtl/mem_share_rqst_arbiter.sv
// rtl/mem_share_rqst_arbiter.sv - round-robin arbiter for one shared column-bank memory / IB-LUT
//
// Purpose: grants one of RQSTR_NUM requestors at a time, registers the grant
// and its column address, and holds it until downstream accepts. Back-to-back
// grants are issued on acceptance while requests remain.
// Ports:
//   sys_clk       clock, rising edge
//   rst           synchronous active-high reset
//   rqst_i        request vector, bit k = requestor k
//   rqst_addr_i   packed column addresses, slice k = requestor k
//   gnt_onehot_o  registered one-hot grant
//   gnt_bin_o     registered binary grant index
//   gnt_addr_o    registered column address of the granted requestor
//   gnt_valid_o   grant outputs hold a valid grant
//   gnt_ready_i   downstream accepts the grant
module mem_share_rqst_arbiter
  import mem_share_pkg::*;
#(
  parameter int RQSTR_NUM          = RQSTR_NUM_DEF,
  parameter int BIN_CODE_LEN       = BIN_CODE_LEN_DEF,
  parameter int RQST_ADDR_BITWIDTH = RQST_ADDR_BITWIDTH_DEF
) (
  input  logic                                    sys_clk,
  input  logic                                    rst,
  input  logic [RQSTR_NUM-1:0]                    rqst_i,
  input  logic [RQSTR_NUM*RQST_ADDR_BITWIDTH-1:0] rqst_addr_i,
  output logic [RQSTR_NUM-1:0]                    gnt_onehot_o,
  output logic [BIN_CODE_LEN-1:0]                 gnt_bin_o,
  output logic [RQST_ADDR_BITWIDTH-1:0]           gnt_addr_o,
  output logic                                    gnt_valid_o,
  input  logic                                    gnt_ready_i
);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [BIN_CODE_LEN-1:0]       r_ptr;
  logic [BIN_CODE_LEN-1:0]       w_ptr_nxt;
  logic [BIN_CODE_LEN-1:0]       w_ptr_inc;
  logic [RQSTR_NUM-1:0]          r_gnt_onehot;
  logic [RQSTR_NUM-1:0]          w_onehot_nxt;
  logic [BIN_CODE_LEN-1:0]       r_gnt_bin;
  logic [BIN_CODE_LEN-1:0]       w_bin_nxt;
  logic [RQST_ADDR_BITWIDTH-1:0] r_gnt_addr;
  logic [RQST_ADDR_BITWIDTH-1:0] w_addr_nxt;
  logic                          w_accept;
  logic                          w_any_rqst;
  logic [RQSTR_NUM-1:0]          w_win_onehot;
  logic [BIN_CODE_LEN-1:0]       w_win_bin;
  logic [RQST_ADDR_BITWIDTH-1:0] w_win_addr;

  assign w_accept   = (r_state == ST_GRANT) && gnt_ready_i;
  assign w_any_rqst = |rqst_i;
  assign w_ptr_inc  = (r_gnt_bin == BIN_CODE_LEN'(RQSTR_NUM - 1)) ? '0 : r_gnt_bin + 1'b1;
  // The encoder sees the post-acceptance pointer so a back-to-back grant
  // already skips past the requestor just served.
  assign w_ptr_nxt  = w_accept ? w_ptr_inc : r_ptr;
  assign w_win_addr = rqst_addr_i[w_win_bin*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];

  mem_share_rr_prio_enc #(
    .RQSTR_NUM    (RQSTR_NUM),
    .BIN_CODE_LEN (BIN_CODE_LEN)
  ) u_prio_enc (
    .rqst_i          (rqst_i),
    .ptr_i           (w_ptr_nxt),
    .winner_onehot_o (w_win_onehot),
    .winner_bin_o    (w_win_bin)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_onehot_nxt = r_gnt_onehot;
    w_bin_nxt    = r_gnt_bin;
    w_addr_nxt   = r_gnt_addr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_rqst) begin
          w_state_nxt  = ST_GRANT;
          w_onehot_nxt = w_win_onehot;
          w_bin_nxt    = w_win_bin;
          w_addr_nxt   = w_win_addr;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          if (w_any_rqst) begin
            w_onehot_nxt = w_win_onehot;
            w_bin_nxt    = w_win_bin;
            w_addr_nxt   = w_win_addr;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_onehot_nxt = '0;
            w_bin_nxt    = '0;
            w_addr_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_onehot_nxt = '0;
        w_bin_nxt    = '0;
        w_addr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_gnt_onehot <= '0;
      r_gnt_bin    <= '0;
      r_gnt_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gnt_onehot <= w_onehot_nxt;
      r_gnt_bin    <= w_bin_nxt;
      r_gnt_addr   <= w_addr_nxt;
    end
  end

  assign gnt_onehot_o = r_gnt_onehot;
  assign gnt_bin_o    = r_gnt_bin;
  assign gnt_addr_o   = r_gnt_addr;
  assign gnt_valid_o  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mem_share_rqst_arbiter.sv
// tb/tb_mem_share_rqst_arbiter.sv - self-checking bench for mem_share_rqst_arbiter
module tb_mem_share_rqst_arbiter;

  localparam int N  = 4;
  localparam int BW = 2;
  localparam int AW = 5;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic [N-1:0]  rqst    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic          ready   = 1'b0;
  logic [N-1:0]  gnt_onehot;
  logic [BW-1:0] gnt_bin;
  logic [AW-1:0] gnt_addr;
  logic          gnt_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  mem_share_rqst_arbiter #(
    .RQSTR_NUM          (N),
    .BIN_CODE_LEN       (BW),
    .RQST_ADDR_BITWIDTH (AW)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .rqst_i       (rqst),
    .rqst_addr_i  (addr),
    .gnt_onehot_o (gnt_onehot),
    .gnt_bin_o    (gnt_bin),
    .gnt_addr_o   (gnt_addr),
    .gnt_valid_o  (gnt_valid),
    .gnt_ready_i  (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [N-1:0] oh, input logic [BW-1:0] b,
                         input logic v);
    chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
    chk({tag, ".bin"},    32'(gnt_bin),    32'(b));
    chk({tag, ".valid"},  32'(gnt_valid),  32'(v));
  endtask

  // Expected grant order for a held 4'b1111 request after reset.
  int exp_seq [5] = '{0, 1, 2, 3, 0};

  logic [N-1:0]    p_onehot, p_rqst;
  logic [BW-1:0]   p_bin;
  logic [AW-1:0]   p_addr;
  logic [N*AW-1:0] p_addr_vec;
  logic            p_valid, p_ready, acc;
  int              wait_cnt [N];
  int              oh_bits;

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    chk_gnt("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.addr", 32'(gnt_addr), 32'h0);

    // Alternating requestors 1 and 3
    rst = 1'b0; rqst = 4'b1010; ready = 1'b1;
    step(); chk_gnt("alt.c1", 4'b0010, 2'd1, 1'b1);
    step(); chk_gnt("alt.c2", 4'b1000, 2'd3, 1'b1);
    step(); chk_gnt("alt.c3", 4'b0010, 2'd1, 1'b1);

    // All requesting: strict rotation, no bubble
    rst = 1'b1; step(); rst = 1'b0;
    rqst = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_gnt($sformatf("all.%0d", i), 4'(1 << exp_seq[i]), 2'(exp_seq[i]), 1'b1);
    end

    // Stall holds grant 2 / addr 0x17 while requests change
    rst = 1'b1; step(); rst = 1'b0;
    ready = 1'b0; rqst = 4'b0100;
    addr = '0; addr[2*AW +: AW] = 5'h17;
    step(); chk_gnt("stall.gnt", 4'b0100, 2'd2, 1'b1);
    chk("stall.addr", 32'(gnt_addr), 32'h17);
    rqst = 4'b0001; addr[0 +: AW] = 5'h03; addr[2*AW +: AW] = 5'h09;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_gnt($sformatf("stall.hold%0d", i), 4'b0100, 2'd2, 1'b1);
      chk($sformatf("stall.hold%0d.addr", i), 32'(gnt_addr), 32'h17);
    end
    ready = 1'b1;
    step(); chk_gnt("stall.next", 4'b0001, 2'd0, 1'b1);
    chk("stall.next.addr", 32'(gnt_addr), 32'h03);

    // Grant 3 accepted with no requests left -> IDLE, pointer wraps to 0
    rqst = 4'b1000;
    step(); chk_gnt("wrap.g3", 4'b1000, 2'd3, 1'b1);
    rqst = 4'b0000;
    step(); chk_gnt("wrap.idle", 4'b0000, 2'd0, 1'b0);
    step(); chk_gnt("wrap.idle2", 4'b0000, 2'd0, 1'b0);
    rqst = 4'b1001;
    step(); chk_gnt("wrap.g0", 4'b0001, 2'd0, 1'b1);

    // Reset during a stalled grant
    ready = 1'b0; rqst = 4'b1001;
    step(); chk_gnt("rstmid.pre", 4'b0001, 2'd0, 1'b1);
    rst = 1'b1;
    step(); chk_gnt("rstmid.rst", 4'b0000, 2'd0, 1'b0);
    chk("rstmid.addr", 32'(gnt_addr), 32'h0);
    rst = 1'b0; rqst = 4'b0110;
    step(); chk_gnt("rstmid.g1", 4'b0010, 2'd1, 1'b1);

    // Random traffic: invariants, stall stability, address capture, starvation bound
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      rqst  = 4'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < N; k++) addr[k*AW +: AW] = 5'($urandom);
      p_onehot = gnt_onehot; p_bin = gnt_bin; p_addr = gnt_addr;
      p_valid = gnt_valid; p_ready = ready; p_rqst = rqst; p_addr_vec = addr;
      acc = p_valid && p_ready;
      step();
      oh_bits = $countones(gnt_onehot);
      chk("rnd.onehot", 32'(oh_bits == (gnt_valid ? 1 : 0)), 32'd1);
      chk("rnd.bin", 32'(gnt_bin), gnt_valid ? 32'($clog2(gnt_onehot)) : 32'd0);
      if (p_valid && !p_ready) begin
        chk("rnd.hold", {25'd0, gnt_valid, gnt_onehot, gnt_bin},
            {25'd0, 1'b1, p_onehot, p_bin});
        chk("rnd.hold.addr", 32'(gnt_addr), 32'(p_addr));
      end else if (gnt_valid) begin
        chk("rnd.winreq", 32'(p_rqst[gnt_bin]), 32'd1);
        chk("rnd.addr", 32'(gnt_addr), 32'(p_addr_vec[gnt_bin*AW +: AW]));
      end else begin
        chk("rnd.idle", 32'(p_rqst), 32'd0);
      end
      for (int k = 0; k < N; k++) begin
        if (!p_rqst[k]) wait_cnt[k] = 0;
        else if (gnt_valid && gnt_onehot[k] && (acc || !p_valid)) wait_cnt[k] = 0;
        else if (acc) wait_cnt[k]++;
      end
      chk("rnd.starve", 32'((wait_cnt[0] > N) || (wait_cnt[1] > N) ||
                             (wait_cnt[2] > N) || (wait_cnt[3] > N)), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
